// File: rtl/daq_l1a_scheduler_if.sv
// Bus bundle between the TTC/ring-buffer side and the L1A readout scheduler.
// The master modport is the environment (TTC inputs, ring reader, AMC13
// status). The slave modport is the scheduler itself.
interface daq_l1a_scheduler_if #(
  parameter int RING_AW = 8,
  parameter int BXN_W   = 12
);
  logic               l1a_in;
  logic [BXN_W-1:0]   bxn_counter;
  logic [RING_AW-1:0] ring_addrw;
  logic [7:0]         l1a_delay;
  logic [2:0]         l1a_window;
  logic               ttc_resync;
  logic               amc13_ready;
  logic               rd_done;
  logic               rd_req;
  logic [RING_AW-1:0] rd_start_addr;
  logic [3:0]         rd_nbx;
  logic [BXN_W-1:0]   rd_bxn;
  logic [23:0]        rd_l1a_num;
  logic               fifo_full;
  logic               fifo_empty;
  logic [15:0]        l1a_ovf_cnt;
  logic               rd_timeout;

  modport master (
    output l1a_in, bxn_counter, ring_addrw, l1a_delay, l1a_window,
           ttc_resync, amc13_ready, rd_done,
    input  rd_req, rd_start_addr, rd_nbx, rd_bxn, rd_l1a_num,
           fifo_full, fifo_empty, l1a_ovf_cnt, rd_timeout
  );

  modport slave (
    input  l1a_in, bxn_counter, ring_addrw, l1a_delay, l1a_window,
           ttc_resync, amc13_ready, rd_done,
    output rd_req, rd_start_addr, rd_nbx, rd_bxn, rd_l1a_num,
           fifo_full, fifo_empty, l1a_ovf_cnt, rd_timeout
  );
endinterface

// File: rtl/daq_l1a_scheduler.sv
// L1A readout scheduler for the DAQ ring buffer.
// Queues each L1A with its event number, BX number and ring write address,
// waits until the readout window has been written and the AMC13 is ready,
// then issues one readout request and waits for the reader to finish.
// Optional build macro DAQ_RD_TIMEOUT_EN: a stuck reader is abandoned after
// 1023 cycles in BUSY and a sticky rd_timeout flag is raised.
module daq_l1a_scheduler #(
  parameter int FIFO_AW = 3,
  parameter int RING_AW = 8,
  parameter int BXN_W   = 12
) (
  input  logic               clk,
  input  logic               daq_reset,
  daq_l1a_scheduler_if.slave bus
);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int ENTRY_W = 24 + BXN_W + RING_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_WAIT_AMC, S_REQ, S_BUSY, S_POP
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               r_state, w_next_state;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_count, w_count_nxt;
  logic                 r_full, r_empty;
  logic [23:0]          r_l1a_cnt;
  logic [15:0]          r_ovf_cnt;
  logic                 r_skip_pop;
  logic [23:0]          r_head_num;
  logic [BXN_W-1:0]     r_head_bxn;
  logic [RING_AW-1:0]   r_start;
  logic                 r_rd_req;
  logic [RING_AW-1:0]   r_rd_start;
  logic [3:0]           r_rd_nbx;
  logic [BXN_W-1:0]     r_rd_bxn;
  logic [23:0]          r_rd_num;
  logic                 w_push, w_drop, w_pop, w_to_hit;
  logic [23:0]          w_num;
  logic [ENTRY_W-1:0]   w_head;
  logic [RING_AW-1:0]   w_avail;

  // An L1A arriving with a resync is discarded outright, never queued or counted.
  assign w_push  = bus.l1a_in && !bus.ttc_resync && !r_full;
  assign w_drop  = bus.l1a_in && !bus.ttc_resync &&  r_full;
  assign w_pop   = (r_state == S_POP) && !r_skip_pop && !bus.ttc_resync;
  assign w_num   = r_l1a_cnt + 24'd1;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_avail = bus.ring_addrw - r_start;

  // Occupancy after this cycle's push/pop, used for the exact full/empty flags.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Queue storage: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_num, bus.bxn_counter, bus.ring_addrw};
  end

  // Queue pointers and registered full/empty; resync flushes everything.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (bus.ttc_resync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Event number (also advances on drops) and saturating drop counter.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset) begin
      r_l1a_cnt <= '0;
      r_ovf_cnt <= '0;
    end else if (bus.ttc_resync) begin
      r_l1a_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (bus.l1a_in) r_l1a_cnt <= w_num;
      if (w_drop)     r_ovf_cnt <= sat_inc16(r_ovf_cnt);
    end
  end

  // A resync during REQ/BUSY lets the event finish but its queue slot is gone,
  // so the following POP must not touch the (possibly refilled) queue.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset)                                                      r_skip_pop <= 1'b0;
    else if (bus.ttc_resync && (r_state == S_REQ || r_state == S_BUSY)) r_skip_pop <= 1'b1;
    else if (r_state == S_POP)                                          r_skip_pop <= 1'b0;
  end

  // Latch the head entry and its window start address when leaving IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_next_state == S_WAIT_DATA) begin
      r_head_num <= w_head[ENTRY_W-1 -: 24];
      r_head_bxn <= w_head[RING_AW +: BXN_W];
      r_start    <= w_head[RING_AW-1:0] - RING_AW'(bus.l1a_delay);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // FSM next-state logic; rd_done outside BUSY is ignored.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (!r_empty && !bus.ttc_resync) w_next_state = S_WAIT_DATA;
      S_WAIT_DATA: if (bus.ttc_resync)                              w_next_state = S_IDLE;
                   else if (w_avail > RING_AW'(bus.l1a_window))     w_next_state = S_WAIT_AMC;
      S_WAIT_AMC:  if (bus.ttc_resync)                              w_next_state = S_IDLE;
                   else if (bus.amc13_ready)                        w_next_state = S_REQ;
      S_REQ:       w_next_state = S_BUSY;
      S_BUSY:      if (bus.rd_done || w_to_hit)                     w_next_state = S_POP;
      S_POP:       w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Request pulse and descriptor, registered on entry to REQ and held after.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset) begin
      r_rd_req   <= 1'b0;
      r_rd_start <= '0;
      r_rd_nbx   <= '0;
      r_rd_bxn   <= '0;
      r_rd_num   <= '0;
    end else begin
      r_rd_req <= (w_next_state == S_REQ);
      if (w_next_state == S_REQ) begin
        r_rd_start <= r_start;
        r_rd_nbx   <= {1'b0, bus.l1a_window} + 4'd1;
        r_rd_bxn   <= r_head_bxn;
        r_rd_num   <= r_head_num;
      end
    end
  end

`ifdef DAQ_RD_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  logic       r_rd_timeout;

  // BUSY-cycle counter; value 1022 marks the 1023rd cycle without rd_done.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset)              r_to_cnt <= '0;
    else if (r_state == S_BUSY) r_to_cnt <= r_to_cnt + 10'd1;
    else                        r_to_cnt <= '0;
  end

  assign w_to_hit = (r_state == S_BUSY) && (r_to_cnt == 10'd1022) && !bus.rd_done;

  // Sticky timeout flag, cleared only by reset or resync.
  always_ff @(posedge clk or posedge daq_reset) begin
    if (daq_reset)           r_rd_timeout <= 1'b0;
    else if (bus.ttc_resync) r_rd_timeout <= 1'b0;
    else if (w_to_hit)       r_rd_timeout <= 1'b1;
  end

  assign bus.rd_timeout = r_rd_timeout;
`else
  assign w_to_hit       = 1'b0;
  assign bus.rd_timeout = 1'b0;
`endif

  assign bus.rd_req        = r_rd_req;
  assign bus.rd_start_addr = r_rd_start;
  assign bus.rd_nbx        = r_rd_nbx;
  assign bus.rd_bxn        = r_rd_bxn;
  assign bus.rd_l1a_num    = r_rd_num;
  assign bus.fifo_full     = r_full;
  assign bus.fifo_empty    = r_empty;
  assign bus.l1a_ovf_cnt   = r_ovf_cnt;
endmodule

// File: tb/tb_daq_l1a_scheduler.sv
// Directed, table-driven bench for daq_l1a_scheduler.
module tb_daq_l1a_scheduler;
  logic clk = 1'b0;
  logic daq_reset;
  always #5 clk = ~clk;

  daq_l1a_scheduler_if #(.RING_AW(8), .BXN_W(12)) bus ();

  daq_l1a_scheduler #(.FIFO_AW(3), .RING_AW(8), .BXN_W(12)) dut (
    .clk       (clk),
    .daq_reset (daq_reset),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0]  ring;
    logic [11:0] bxn;
    logic [7:0]  delay;
    logic [2:0]  win;
    logic [7:0]  exp_start;
    logic [3:0]  exp_nbx;
  } vec_t;

  vec_t        tbl [5];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          req_cnt = 0;
  logic        prev_req = 1'b0;
  logic [7:0]  cap_start, cap_ring;
  logic [3:0]  cap_nbx;
  logic [11:0] cap_bxn;
  logic [23:0] cap_num;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One BX: sample outputs 1 ns after the edge, then advance ring/BX counters.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.rd_req === 1'b1) begin
      n_cmp++;
      if (prev_req) begin
        n_bad++;
        $display("FAIL rd_req_width: got pulse longer than 1 cycle, want 1 cycle");
      end
      req_cnt++;
      cap_start = bus.rd_start_addr;
      cap_nbx   = bus.rd_nbx;
      cap_bxn   = bus.rd_bxn;
      cap_num   = bus.rd_l1a_num;
      cap_ring  = bus.ring_addrw;
    end
    prev_req = bus.rd_req;
    bus.ring_addrw  = bus.ring_addrw + 8'd1;
    bus.bxn_counter = bus.bxn_counter + 12'd1;
  endtask

  task automatic wait_req(input int budget, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      if (bus.rd_req === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got no rd_req within %0d cycles, want one", tag, budget);
    end
  endtask

  task automatic serve_one(input int exp_num, input string tag);
    bit ok;
    wait_req(40, tag, ok);
    if (ok) chk({tag, "_num"}, 32'(cap_num), 32'(exp_num));
    cyc();
    bus.rd_done = 1'b1;
    cyc();
    bus.rd_done = 1'b0;
  endtask

  task automatic push_l1a(input int n);
    bus.l1a_in = 1'b1;
    repeat (n) cyc();
    bus.l1a_in = 1'b0;
  endtask

  task automatic do_reset();
    daq_reset       = 1'b1;
    bus.l1a_in      = 1'b0;
    bus.ttc_resync  = 1'b0;
    bus.rd_done     = 1'b0;
    bus.amc13_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    daq_reset = 1'b0;
    prev_req  = 1'b0;
  endtask

  initial begin
    bit ok;
    int base;
    logic [7:0] av;

    tbl[0] = '{ring: 8'h20, bxn: 12'h123, delay: 8'h01, win: 3'd7, exp_start: 8'h1F, exp_nbx: 4'd8};
    tbl[1] = '{ring: 8'h00, bxn: 12'h456, delay: 8'h03, win: 3'd2, exp_start: 8'hFD, exp_nbx: 4'd3};
    tbl[2] = '{ring: 8'h80, bxn: 12'hFFF, delay: 8'h10, win: 3'd0, exp_start: 8'h70, exp_nbx: 4'd1};
    tbl[3] = '{ring: 8'h05, bxn: 12'h001, delay: 8'h40, win: 3'd4, exp_start: 8'hC5, exp_nbx: 4'd5};
    tbl[4] = '{ring: 8'hFE, bxn: 12'h800, delay: 8'h00, win: 3'd7, exp_start: 8'hFE, exp_nbx: 4'd8};

    daq_reset       = 1'b1;
    bus.l1a_in      = 1'b0;
    bus.bxn_counter = '0;
    bus.ring_addrw  = '0;
    bus.l1a_delay   = '0;
    bus.l1a_window  = '0;
    bus.ttc_resync  = 1'b0;
    bus.amc13_ready = 1'b0;
    bus.rd_done     = 1'b0;
    do_reset();

    chk("rst_rd_req",     32'(bus.rd_req),        32'd0);
    chk("rst_start",      32'(bus.rd_start_addr), 32'd0);
    chk("rst_nbx",        32'(bus.rd_nbx),        32'd0);
    chk("rst_bxn",        32'(bus.rd_bxn),        32'd0);
    chk("rst_num",        32'(bus.rd_l1a_num),    32'd0);
    chk("rst_full",       32'(bus.fifo_full),     32'd0);
    chk("rst_empty",      32'(bus.fifo_empty),    32'd1);
    chk("rst_ovf",        32'(bus.l1a_ovf_cnt),   32'd0);
    chk("rst_timeout",    32'(bus.rd_timeout),    32'd0);

    // Single-event table: one L1A per row, numbers 1..5 in row order.
    bus.amc13_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      bus.ring_addrw  = tbl[r].ring;
      bus.bxn_counter = tbl[r].bxn;
      bus.l1a_delay   = tbl[r].delay;
      bus.l1a_window  = tbl[r].win;
      push_l1a(1);
      wait_req(40, "row_req", ok);
      if (ok) begin
        chk("row_start", 32'(cap_start), 32'(tbl[r].exp_start));
        chk("row_nbx",   32'(cap_nbx),   32'(tbl[r].exp_nbx));
        chk("row_bxn",   32'(cap_bxn),   32'(tbl[r].bxn));
        chk("row_num",   32'(cap_num),   32'(r + 1));
        av = cap_ring - tbl[r].exp_start;
        chk("row_data_ready", 32'(av >= 8'(tbl[r].exp_nbx)), 32'd1);
      end
      repeat (2) cyc();
      bus.rd_done = 1'b1;
      cyc();
      bus.rd_done = 1'b0;
      repeat (4) cyc();
      chk("row_hold_start", 32'(bus.rd_start_addr), 32'(tbl[r].exp_start));
      chk("row_empty",      32'(bus.fifo_empty),    32'd1);
    end

    // Back-pressure: three queued L1As held off by amc13_ready=0.
    do_reset();
    bus.l1a_delay  = 8'd0;
    bus.l1a_window = 3'd0;
    push_l1a(3);
    base = req_cnt;
    repeat (50) cyc();
    chk("bp_no_req", 32'(req_cnt), 32'(base));
    bus.amc13_ready = 1'b1;
    serve_one(1, "bp1");
    serve_one(2, "bp2");
    serve_one(3, "bp3");
    repeat (3) cyc();
    chk("bp_empty", 32'(bus.fifo_empty), 32'd1);

    // Overflow: 10 L1As, rd_done withheld; head stays queued while in BUSY.
    do_reset();
    bus.amc13_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.l1a_in = 1'b1;
      cyc();
      chk("ovf_full_step", 32'(bus.fifo_full), 32'(i >= 7));
    end
    bus.l1a_in = 1'b0;
    chk("ovf_cnt",   32'(bus.l1a_ovf_cnt), 32'd2);
    chk("ovf_first", 32'(cap_num),         32'd1);
    cyc();
    bus.rd_done = 1'b1;
    cyc();
    bus.rd_done = 1'b0;
    for (int k = 2; k <= 8; k++) serve_one(k, "ovf_srv");
    repeat (3) cyc();
    chk("ovf_drain_empty", 32'(bus.fifo_empty), 32'd1);
    chk("ovf_drain_full",  32'(bus.fifo_full),  32'd0);
    push_l1a(1);
    serve_one(11, "ovf_next");

    // Resync in BUSY together with an L1A, 4 entries still queued.
    do_reset();
    push_l1a(5);
    bus.amc13_ready = 1'b1;
    serve_one(1, "rs_head");
    bus.rd_done = 1'b0;
    do_reset();
    bus.amc13_ready = 1'b0;
    push_l1a(5);
    bus.amc13_ready = 1'b1;
    wait_req(40, "rs_req", ok);
    if (ok) chk("rs_req_num", 32'(cap_num), 32'd1);
    cyc();
    bus.ttc_resync = 1'b1;
    bus.l1a_in     = 1'b1;
    cyc();
    bus.ttc_resync = 1'b0;
    bus.l1a_in     = 1'b0;
    chk("rs_empty", 32'(bus.fifo_empty),  32'd1);
    chk("rs_ovf",   32'(bus.l1a_ovf_cnt), 32'd0);
    repeat (2) cyc();
    bus.rd_done = 1'b1;
    cyc();
    bus.rd_done = 1'b0;
    base = req_cnt;
    repeat (30) cyc();
    chk("rs_no_req",     32'(req_cnt),        32'(base));
    chk("rs_empty_hold", 32'(bus.fifo_empty), 32'd1);
    push_l1a(1);
    serve_one(1, "rs_next");

    // Resync while waiting for the AMC13: request abandoned.
    bus.amc13_ready = 1'b0;
    push_l1a(1);
    repeat (5) cyc();
    bus.ttc_resync = 1'b1;
    cyc();
    bus.ttc_resync  = 1'b0;
    bus.amc13_ready = 1'b1;
    base = req_cnt;
    repeat (20) cyc();
    chk("rsw_no_req", 32'(req_cnt),        32'(base));
    chk("rsw_empty",  32'(bus.fifo_empty), 32'd1);
    push_l1a(1);
    serve_one(1, "rsw_next");

    // Asynchronous reset while rd_req is high.
    push_l1a(1);
    wait_req(40, "ar_req", ok);
    daq_reset = 1'b1;
    #1;
    chk("ar_rd_req", 32'(bus.rd_req),        32'd0);
    chk("ar_num",    32'(bus.rd_l1a_num),    32'd0);
    chk("ar_start",  32'(bus.rd_start_addr), 32'd0);
    chk("ar_empty",  32'(bus.fifo_empty),    32'd1);
    #2;
    daq_reset = 1'b0;
    prev_req  = 1'b0;

    // Reader never answers.
    do_reset();
    bus.amc13_ready = 1'b1;
    push_l1a(2);
    wait_req(40, "to_req", ok);
`ifdef DAQ_RD_TIMEOUT_EN
    repeat (1023) cyc();
    chk("to_before", 32'(bus.rd_timeout), 32'd0);
    cyc();
    chk("to_set", 32'(bus.rd_timeout), 32'd1);
    serve_one(2, "to_next");
    chk("to_sticky", 32'(bus.rd_timeout), 32'd1);
    bus.ttc_resync = 1'b1;
    cyc();
    bus.ttc_resync = 1'b0;
    chk("to_clear", 32'(bus.rd_timeout), 32'd0);
`else
    base = req_cnt;
    repeat (1100) cyc();
    chk("busy_no_req",  32'(req_cnt),        32'(base));
    chk("busy_timeout", 32'(bus.rd_timeout), 32'd0);
    bus.rd_done = 1'b1;
    cyc();
    bus.rd_done = 1'b0;
    serve_one(2, "busy_next");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
